// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI4 burst write master.
// Holds the FSM state encoding, AXI burst/response encodings and a
// constant log2 helper used for awsize and address alignment.
package axi_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int unsigned BOUNDARY_4K = 4096;

    // Ceiling log2 for elaboration-time constants (v >= 1).
    function automatic int unsigned log2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_burst_write_master.sv
// AXI4 single-burst INCR write initiator.
// Accepts one command (start address, awlen-encoded beat count), issues AW,
// streams payload beats from a valid/ready source straight onto W, collects B
// and reports done/error. Bursts crossing a 4 KB boundary are rejected
// without any bus activity.
//
// Ports:
//   axi_aclk, axi_areset         clock, async active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_addr, cmd_len payload
//   s_valid/s_ready/s_data       payload source
//   busy, done, error            status (done = 1-cycle pulse, error sticky)
//   axi_aw*, axi_w*, axi_b*      AXI4 write channels
//   err_count                    only with AXI_WR_BID_CHECK_EN
//
// Build option: define AXI_WR_BID_CHECK_EN to flag bid != AXI_ID as an error
// and to add the saturating err_count output.
module axi_burst_write_master
    import axi_master_pkg::*;
#(
    parameter int unsigned AXI_AWIDTH  = 64,
    parameter int unsigned AXI_DWIDTH  = 64,
    parameter int unsigned AXI_IDWIDTH = 4,
    parameter int unsigned AXI_ID      = 0
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_AWIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,

    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [AXI_DWIDTH-1:0]     s_data,

    output logic                      busy,
    output logic                      done,
    output logic                      error,

    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [AXI_AWIDTH-1:0]     axi_awaddr,
    output logic [7:0]                axi_awlen,
    output logic [AXI_IDWIDTH-1:0]    axi_awid,
    output logic [2:0]                axi_awsize,
    output logic [1:0]                axi_awburst,

    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    output logic                      axi_wlast,
    output logic [AXI_DWIDTH-1:0]     axi_wdata,
    output logic [AXI_DWIDTH/8-1:0]   axi_wstrb,

    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    input  logic [AXI_IDWIDTH-1:0]    axi_bid,
    input  logic [1:0]                axi_bresp
`ifdef AXI_WR_BID_CHECK_EN
    ,
    output logic [15:0]               err_count
`endif
);

    localparam int unsigned BPB       = AXI_DWIDTH / 8;
    localparam int unsigned SIZE_LOG2 = log2_f(BPB);
    // Wide enough for 4095 + 256 beats * 64 bytes.
    localparam int unsigned SPAN_W    = 16;
    localparam logic [AXI_AWIDTH-1:0] ADDR_MASK = ~AXI_AWIDTH'(BPB - 1);

    state_e                  state_q, state_d;
    logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic [AXI_AWIDTH-1:0]   cmd_addr_aligned_c;
    logic [SPAN_W-1:0]       span_end_c;
    logic                    cross_4k_c;
    logic                    bad_resp_c;

    // Burst end offset within its 4 KB page, from the aligned start address.
    assign cmd_addr_aligned_c = cmd_addr & ADDR_MASK;
    assign span_end_c = SPAN_W'(cmd_addr_aligned_c[11:0])
                      + ((SPAN_W'(cmd_len) + SPAN_W'(1)) << SIZE_LOG2);
    assign cross_4k_c = span_end_c > SPAN_W'(BOUNDARY_4K);

`ifdef AXI_WR_BID_CHECK_EN
    assign bad_resp_c = (axi_bresp != AXI_RESP_OKAY)
                     || (axi_bid != AXI_IDWIDTH'(AXI_ID));
`else
    // Response ID is deliberately not checked in this build.
    logic unused_bid_c;
    assign unused_bid_c = ^axi_bid;
    assign bad_resp_c   = (axi_bresp != AXI_RESP_OKAY);
`endif

    // State register.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched command, beat counter and status flops.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        error_d = error_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr_aligned_c;
                    len_d   = cmd_len;
                    cnt_d   = cmd_len;
                    error_d = 1'b0;
                    if (cross_4k_c) begin
                        // Rejected: report immediately, never touch the bus.
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (axi_awready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (s_valid && axi_wready) begin
                    if (cnt_q == 8'd0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            RESP: begin
                if (axi_bvalid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (bad_resp_c) begin
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State-decoded handshakes; W is a zero-latency pass-through of the source.
    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        s_ready     = 1'b0;
        axi_wlast   = 1'b0;
        axi_bready  = 1'b0;
        unique case (state_q)
            IDLE: cmd_ready = ~axi_areset;
            ADDR: begin
                busy        = 1'b1;
                axi_awvalid = 1'b1;
            end
            DATA: begin
                busy       = 1'b1;
                axi_wvalid = s_valid;
                s_ready    = axi_wready;
                axi_wlast  = (cnt_q == 8'd0);
            end
            RESP: begin
                busy       = 1'b1;
                axi_bready = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign axi_awaddr  = addr_q;
    assign axi_awlen   = len_q;
    assign axi_awid    = AXI_IDWIDTH'(AXI_ID);
    assign axi_awsize  = 3'(SIZE_LOG2);
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_wdata   = s_data;
    assign axi_wstrb   = '1;
    assign done        = done_q;
    assign error       = error_q;

`ifdef AXI_WR_BID_CHECK_EN
    logic [15:0] err_count_q, err_count_d;

    // One increment per burst that finishes with error set; saturates.
    always_comb begin
        err_count_d = err_count_q;
        if (done_d && error_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: doc/axi_burst_write_master.md
Name: axi_burst_write_master

Overview:
- AXI4 memory-mapped write initiator: the master-side counterpart of our AXI-MM responder.
- Takes a single-burst command (address, beat count) and streams payload beats from a valid/ready source (TDC readout FIFO) into an INCR burst on the AW/W channels.
- Collects the B response and reports done/error to the control logic.
- Handles one burst at a time; intended to push TDC event data toward host memory over the PCIe bridge.

Parameters:
- AXI_AWIDTH, 64, address width.
- AXI_DWIDTH, 64, data width; power of two, 32..512.
- AXI_IDWIDTH, 4, ID width.
- AXI_ID, 0, constant ID driven on axi_awid.

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_addr  in  AXI_AWIDTH  burst start byte address.
- cmd_len  in  8  beats minus one (AXI awlen encoding).
- s_valid  in  1  payload beat valid.
- s_ready  out  1  payload beat consumed.
- s_data  in  AXI_DWIDTH  payload data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the burst completes or is rejected.
- error  out  1  sticky error flag; cleared on next command acceptance.
- axi_awvalid out 1; axi_awready in 1; axi_awaddr out AXI_AWIDTH; axi_awlen out 8; axi_awid out AXI_IDWIDTH; axi_awsize out 3; axi_awburst out 2.
- axi_wvalid out 1; axi_wready in 1; axi_wlast out 1; axi_wdata out AXI_DWIDTH; axi_wstrb out AXI_DWIDTH/8.
- axi_bvalid in 1; axi_bready out 1; axi_bid in AXI_IDWIDTH; axi_bresp in 2.

Behaviour:
- One clock, axi_aclk. Reset asynchronous, active-high (axi_areset).
- Reset values: state IDLE; all valid/ready/done/error/busy outputs 0; latched addr/len 0; beat counter 0.
- Reset mid-burst: abandon immediately, no further AW/W/B activity (interconnect is reset on the same signal).
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid:
    - Latch addr with low log2(AXI_DWIDTH/8) bits forced to 0, latch len, counter=len, clear error.
    - If addr[11:0] + (len+1)*bytes_per_beat > 4096 (burst crosses a 4 KB boundary): set error, pulse done next cycle, stay IDLE, issue no AW.
    - Otherwise go to ADDR.
  - ADDR: awvalid=1, awaddr/awlen from latches, awid=AXI_ID, awsize=log2(AXI_DWIDTH/8), awburst=INCR (2'b01). AW outputs held stable until awready. On awready go to DATA.
  - DATA: combinational pass-through with zero latency: axi_wvalid=s_valid, s_ready=axi_wready, wdata=s_data, wstrb all ones, wlast=(counter==0). On each wvalid&wready: counter-1; if counter==0 go to RESP.
  - RESP: bready=1. On bvalid: go to IDLE, pulse done (registered, cycle after handshake), error|=(bresp!=OKAY).
- s_ready=0 and wvalid=0 outside DATA; no W beat is ever issued before its AW is accepted.
- cmd_ready=0 outside IDLE; a command offered while busy waits.
- len=0: single beat, wlast high on that beat.
- len=255: 256 beats; the counter is 8 bits and must not wrap before wlast.
- A source stall (s_valid low) mid-burst inserts wvalid gaps only; wlast stays tied to the counter.
- Back-to-back commands: the earliest new AW is 1 cycle after the done pulse's B handshake cycle (IDLE visit of one cycle).

Optional Feature:
- Macro AXI_WR_BID_CHECK_EN.
- Defined:
  - In RESP, a bvalid with axi_bid != AXI_ID is a protocol error: set error, still complete the burst.
  - Adds a 16-bit saturating output err_count, incremented once per burst that ends with error set (reject, bad bresp or bad bid). Reset to 0.
- Undefined: bid ignored; err_count port absent.

Decomposition:
- Package axi_master_pkg:
  - State enum (IDLE, ADDR, DATA, RESP).
  - Constants AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00.
  - Automatic log2 function for awsize and address masking.
- No sub-module: counter and FSM stay in one block.

Test Plan:
- cmd addr 0x1000, len 3, source always valid, awready/wready/bvalid immediate -> awaddr 0x1000, awlen 3, awsize 3, 4 W beats with wlast on beat 4, done pulse, error 0.
- cmd addr 0x1007, len 0 -> awaddr 0x1000, single beat with wlast=1.
- cmd addr 0x0FF8, len 1 (crosses 4 KB) -> no awvalid, done pulse, error=1; next legal command clears error.
- len 255, random s_valid/wready stalls -> exactly 256 beats, data order preserved, wlast only on beat 256, AW held stable during 5 stalled awready cycles.
- bresp=2'b10 -> error=1 after done; with AXI_WR_BID_CHECK_EN, bid=5 -> error=1, err_count=1.
- Assert axi_areset mid-DATA after beat 2 of 8 -> all valids, s_ready and bready drop asynchronously, busy=0; next command proceeds normally.
